// File: rtl/conv_accel_sequencer.sv
// Per-window job sequencer for the convolution accelerator: load, start, wait, return result.
// Optional WAIT timeout with sticky err is enabled by defining CONV_SEQ_TIMEOUT_EN.
module conv_accel_sequencer #(
   parameter int DATA_W  = 32,
   parameter int WIN_LEN = 9,
   parameter int TIMEOUT = 1024
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              clr,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic [DATA_W-1:0] acc_data,
   output logic              acc_wr,
   input  logic              acc_full,
   input  logic              acc_empty,
   output logic              acc_start,
   input  logic              acc_ready,
   input  logic [DATA_W-1:0] acc_sum,
   output logic              r_valid,
   input  logic              r_ready,
   output logic [DATA_W-1:0] r_data,
   output logic              busy,
   output logic              err,
   output logic [15:0]       job_cnt
);

   typedef enum logic [2:0] {
      IDLE, LOAD, START, WAIT, RESULT, ERROR
   } state_t;

   localparam logic [7:0] LAST = 8'(WIN_LEN);

   state_t     state, state_d;
   logic [7:0] cnt, cnt_nxt;
   logic       take, last, rdy, tmo;
   logic       unused;

   assign s_ready = Rst && !clr && !acc_full
                    && (state == IDLE || state == LOAD);
   assign take    = s_valid && s_ready;
   assign cnt_nxt = (state == IDLE) ? 8'd1 : cnt + 8'd1;
   assign last    = (cnt_nxt == LAST);
   // the accelerator may still show a stale cReady while cStart is high
   assign rdy     = acc_ready && !acc_start;
   assign busy    = (state != IDLE);
   assign unused  = acc_empty | (TIMEOUT == 0);

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (take) state_d = last ? START : LOAD;
         LOAD:    if (take && last) state_d = START;
         START:   state_d = WAIT;
         WAIT: begin
            if (rdy)      state_d = RESULT;
            else if (tmo) state_d = ERROR;
         end
         RESULT:  if (r_ready) state_d = IDLE;
         ERROR:   state_d = ERROR;
         default: state_d = IDLE;
      endcase
      if (clr) state_d = IDLE;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= state_d;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt       <= '0;
         acc_data  <= '0;
         acc_wr    <= 1'b0;
         acc_start <= 1'b0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         job_cnt   <= '0;
      end else if (clr) begin
         cnt       <= '0;
         acc_wr    <= 1'b0;
         acc_start <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         acc_wr    <= take;
         acc_start <= (state == START);
         if (take) begin
            acc_data <= s_data;
            cnt      <= cnt_nxt;
         end
         if (state == WAIT && rdy) begin
            r_data  <= acc_sum;
            r_valid <= 1'b1;
         end
         if (state == RESULT && r_ready) begin
            r_valid <= 1'b0;
            job_cnt <= job_cnt + 16'd1;
         end
      end
   end

`ifdef CONV_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] tcnt;
   logic          err_q;

   assign tmo = (state == WAIT) && !rdy && (tcnt == TLAST);
   assign err = err_q;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else if (clr) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         tcnt <= (state == WAIT) ? tcnt + TW'(1) : '0;
         if (tmo) err_q <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

endmodule
